graphics_bus_arbiter: RTL

- Owns the Graphics ASIC register databus: chipselect, read, data_address, databus.
- Shares the bus between two requesters.
  - CPU port: single-word reads and writes.
  - Game-logic update port: atomic burst write of all game-state registers (paddles, ball, scores, state).
- Keeps bursts out of the ASIC's end-of-frame latch window, so a frame never shows half-updated state.
- Sits between the memory-mapped CPU interface and the ASIC; a top-level tristate drives databus from bus_dout/bus_oe.

---
 rtl/graphics_bus_pkg.sv | 26 ++
 rtl/graphics_bus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/graphics_bus_pkg.sv
// rtl/graphics_bus_pkg.sv - state encoding and register map shared by the graphics bus arbiter
package graphics_bus_pkg;

    localparam int GFX_NUM_REGS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_WR,
        ST_CPU_RD,
        ST_RD_WAIT,
        ST_TURN,
        ST_BURST
    } gfx_state_t;

    localparam logic [3:0] REG_PADDLE1_X  = 4'd0;
    localparam logic [3:0] REG_PADDLE1_Y  = 4'd1;
    localparam logic [3:0] REG_PADDLE2_X  = 4'd2;
    localparam logic [3:0] REG_PADDLE2_Y  = 4'd3;
    localparam logic [3:0] REG_BALL_X     = 4'd4;
    localparam logic [3:0] REG_BALL_Y     = 4'd5;
    localparam logic [3:0] REG_BALL_Z     = 4'd6;
    localparam logic [3:0] REG_P1_SCORE   = 4'd7;
    localparam logic [3:0] REG_P2_SCORE   = 4'd8;
    localparam logic [3:0] REG_GAME_STATE = 4'd9;

endpackage

// File: rtl/graphics_bus_arbiter.sv
// rtl/graphics_bus_arbiter.sv - shares the graphics ASIC register bus between CPU accesses and atomic game-state bursts
module graphics_bus_arbiter
    import graphics_bus_pkg::*;
#(
    parameter int NUM_REGS     = GFX_NUM_REGS,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [3:0]             cpu_addr,
    input  logic [15:0]            cpu_wdata,
    output logic                   cpu_gnt,
    output logic [15:0]            cpu_rdata,
    output logic                   cpu_rvalid,
    input  logic                   upd_req,
    input  logic [16*NUM_REGS-1:0] upd_data,
    output logic                   upd_ack,
    input  logic                   latch_window,
    output logic                   bus_cs,
    output logic                   bus_read,
    output logic [3:0]             bus_addr,
    output logic [15:0]            bus_dout,
    output logic                   bus_oe,
    input  logic [15:0]            bus_din,
    output logic                   busy
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]      LAST_IDX   = 4'(NUM_REGS - 1);

    generate
        if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
            $error("graphics_bus_arbiter: NUM_REGS must be within 1..16");
        end
    endgenerate

    gfx_state_t    state;
    logic [SW-1:0] starve;
    logic [3:0]    idx;
    logic [3:0]    lat_addr;
    logic [15:0]   lat_wdata;
    logic          ack_pend;
    logic [15:0]   snap [NUM_REGS];

    logic          upd_blocked;
    logic          starved;
    logic          burst_go;

    // The requester still holds upd_req until it sees upd_ack, so the finished
    // update must not be taken again during the two cycles around the ack.
    assign upd_blocked = ack_pend | upd_ack;
    assign starved     = (starve >= STARVE_MAX);
    assign burst_go    = (state == ST_IDLE) & upd_req & ~upd_blocked & ~latch_window
                       & (starved | ~cpu_req);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (burst_go) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= upd_data[16*i +: 16];
            end
        end
    end

    // Bus outputs are registered from the current state, so each bus cycle
    // appears one clock after the state that schedules it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            starve     <= '0;
            idx        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ack_pend   <= 1'b0;
            cpu_gnt    <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            upd_ack    <= 1'b0;
            bus_cs     <= 1'b0;
            bus_read   <= 1'b0;
            bus_addr   <= '0;
            bus_dout   <= '0;
            bus_oe     <= 1'b0;
        end else begin
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            upd_ack    <= ack_pend;
            ack_pend   <= 1'b0;
            bus_cs     <= 1'b0;
            bus_read   <= 1'b0;
            bus_addr   <= '0;
            bus_dout   <= '0;
            bus_oe     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (burst_go) begin
                        state  <= ST_BURST;
                        idx    <= '0;
                        starve <= '0;
                    end else begin
                        if (upd_req && !upd_blocked && !starved) begin
                            starve <= starve + 1'b1;
                        end
                        if (cpu_req) begin
                            cpu_gnt   <= 1'b1;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                            state     <= cpu_we ? ST_CPU_WR : ST_CPU_RD;
                        end
                    end
                end
                ST_CPU_WR: begin
                    bus_cs   <= 1'b1;
                    bus_oe   <= 1'b1;
                    bus_addr <= lat_addr;
                    bus_dout <= lat_wdata;
                    state    <= ST_IDLE;
                end
                ST_CPU_RD: begin
                    bus_cs   <= 1'b1;
                    bus_read <= 1'b1;
                    bus_addr <= lat_addr;
                    state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state <= ST_TURN;
                end
                ST_TURN: begin
                    cpu_rdata  <= bus_din;
                    cpu_rvalid <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_BURST: begin
                    bus_cs   <= 1'b1;
                    bus_oe   <= 1'b1;
                    bus_addr <= idx;
                    bus_dout <= snap[idx];
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        ack_pend <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
